demux4_stream: RTL and testbench

Stream demultiplexer that steers one N-bit input stream to one of four output streams, selected per transfer by a 2-bit route field. It is the counterpart of the 4:1 `mux4`: `mux4` merges four sources onto one bus, and this block fans one producer out to four consumers. Each output carries a one-entry register slice with valid/ready handshake, so a stalled consumer blocks only transfers routed to it.

---
 rtl/demux4_pkg.sv | 13 +
 rtl/demux4_slot.sv | 70 +++++++
 rtl/demux4_stream.sv | 59 +++++
 tb/tb_demux4_stream.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/demux4_pkg.sv
// Shared types and constants for the demux4_stream slice.
// Used by demux4_slot and demux4_stream.
package demux4_pkg;

    typedef logic [1:0] route_t;

    localparam int NUM_OUTPUTS = 4;

    function automatic logic [NUM_OUTPUTS-1:0] route_onehot(input route_t r);
        return NUM_OUTPUTS'(1) << r;
    endfunction

endpackage

// File: rtl/demux4_slot.sv
// One-entry output register slice with valid/ready handshake.
// With DEMUX4_COUNT_EN defined it also counts drained transfers.
module demux4_slot #(
    parameter int N = 32
`ifdef DEMUX4_COUNT_EN
    , parameter int CW = 16
`endif
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          load,
    input  logic [N-1:0]  load_data,
    output logic [N-1:0]  out_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic          free
`ifdef DEMUX4_COUNT_EN
    , output logic [CW-1:0] out_count
`endif
);

    logic          valid_q, valid_d;
    logic [N-1:0]  data_q, data_d;
    logic          drain;

    assign drain = valid_q & out_ready;
    assign free  = ~valid_q | out_ready;

    // A load wins over a drain in the same cycle, keeping one transfer per cycle.
    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (load) begin
            valid_d = 1'b1;
            data_d  = load_data;
        end else if (drain) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign out_data  = data_q;
    assign out_valid = valid_q;

`ifdef DEMUX4_COUNT_EN
    logic [CW-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (drain) count_d = count_q + CW'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) count_q <= '0;
        else        count_q <= count_d;
    end

    assign out_count = count_q;
`endif

endmodule

// File: rtl/demux4_stream.sv
// 1:4 stream demultiplexer: in_select routes each transfer to one of four slices.
// Optional per-output transfer counters under DEMUX4_COUNT_EN.
module demux4_stream
    import demux4_pkg::*;
#(
    parameter int N = 32
`ifdef DEMUX4_COUNT_EN
    , parameter int CW = 16
`endif
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic [N-1:0]                     in_data,
    input  route_t                           in_select,
    input  logic                             in_valid,
    output logic                             in_ready,
    output logic [NUM_OUTPUTS-1:0][N-1:0]    out_data,
    output logic [NUM_OUTPUTS-1:0]           out_valid,
    input  logic [NUM_OUTPUTS-1:0]           out_ready
`ifdef DEMUX4_COUNT_EN
    , output logic [NUM_OUTPUTS-1:0][CW-1:0] out_count
`endif
);

    logic [NUM_OUTPUTS-1:0] slot_free;
    logic [NUM_OUTPUTS-1:0] slot_load;
    logic                   in_fire;

    // Ready depends only on the addressed slot, never on in_valid.
    assign in_ready = rst_n & slot_free[in_select];
    assign in_fire  = in_valid & in_ready;

    always_comb begin
        slot_load = '0;
        if (in_fire) slot_load = route_onehot(in_select);
    end

    for (genvar k = 0; k < NUM_OUTPUTS; k++) begin : g_slot
        demux4_slot #(
            .N  (N)
`ifdef DEMUX4_COUNT_EN
            , .CW (CW)
`endif
        ) u_slot (
            .clk       (clk),
            .rst_n     (rst_n),
            .load      (slot_load[k]),
            .load_data (in_data),
            .out_data  (out_data[k]),
            .out_valid (out_valid[k]),
            .out_ready (out_ready[k]),
            .free      (slot_free[k])
`ifdef DEMUX4_COUNT_EN
            , .out_count (out_count[k])
`endif
        );
    end

endmodule

// File: tb/tb_demux4_stream.sv
// Directed bench for demux4_stream with a queue-based reference model.
module tb_demux4_stream;

    localparam int N  = 32;
    localparam int CW = 4;

    logic                  clk = 1'b0;
    logic                  rst_n;
    logic [N-1:0]          in_data;
    logic [1:0]            in_select;
    logic                  in_valid;
    logic                  in_ready;
    logic [3:0][N-1:0]     out_data;
    logic [3:0]            out_valid;
    logic [3:0]            out_ready;
`ifdef DEMUX4_COUNT_EN
    logic [3:0][CW-1:0]    out_count;
`endif

    demux4_stream #(
        .N (N)
`ifdef DEMUX4_COUNT_EN
        , .CW (CW)
`endif
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_data   (in_data),
        .in_select (in_select),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready)
`ifdef DEMUX4_COUNT_EN
        , .out_count (out_count)
`endif
    );

    always #5 clk = ~clk;

    int n_total = 0;
    int n_pass  = 0;
    bit chk_en  = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    // Reference model: each output is a FIFO of depth one; a word pushed at an
    // edge is visible after it, a consumer pop happens at the edge where ready=1.
    typedef logic [N-1:0] word_q_t [$];
    word_q_t     mq [4];
    logic [CW-1:0] mcnt [4];

    function automatic bit model_ready();
        return rst_n && (mq[in_select].size() == 0 || out_ready[in_select]);
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < 4; k++) begin
                mq[k].delete();
                mcnt[k] = '0;
            end
        end else begin
            bit       acc;
            int       dst;
            logic [N-1:0] w;
            acc = in_valid && model_ready();
            dst = int'(in_select);
            w   = in_data;
            for (int k = 0; k < 4; k++) begin
                if (mq[k].size() > 0 && out_ready[k]) begin
                    void'(mq[k].pop_front());
                    mcnt[k] = mcnt[k] + CW'(1);
                end
            end
            if (acc) mq[dst].push_back(w);
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("in_ready_model", {63'd0, in_ready}, {63'd0, model_ready()});
            for (int k = 0; k < 4; k++) begin
                check($sformatf("out_valid_model[%0d]", k), {63'd0, out_valid[k]},
                      {63'd0, mq[k].size() > 0});
                if (mq[k].size() > 0)
                    check($sformatf("out_data_model[%0d]", k), {32'd0, out_data[k]},
                          {32'd0, mq[k][0]});
`ifdef DEMUX4_COUNT_EN
                check($sformatf("out_count_model[%0d]", k), {60'd0, out_count[k]},
                      {60'd0, mcnt[k]});
`endif
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [1:0] sel, input logic [N-1:0] d);
        in_valid  = 1'b1;
        in_select = sel;
        in_data   = d;
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b1;
        in_select = 2'd2;
        in_data   = 32'hDEAD_BEEF;
        out_ready = 4'b0000;

        // Reset held with in_valid high
        repeat (2) step();
        @(negedge clk);
        check("rst_in_ready", {63'd0, in_ready}, 64'd0);
        check("rst_out_valid", {60'd0, out_valid}, 64'd0);
        for (int k = 0; k < 4; k++)
            check($sformatf("rst_out_data[%0d]", k), {32'd0, out_data[k]}, 64'd0);
        step();

        rst_n  = 1'b1;
        chk_en = 1'b1;
        send(2'd2, 32'hA5A5_A5A5);
        @(negedge clk);
        check("first_in_ready", {63'd0, in_ready}, 64'd1);
        step();
        in_valid = 1'b0;
        @(negedge clk);
        check("first_out_valid", {60'd0, out_valid}, 64'h4);
        check("first_out_data2", {32'd0, out_data[2]}, 64'hA5A5_A5A5);
        step();

        // Streaming to all four outputs
        out_ready = 4'hF;
        for (int i = 0; i < 4; i++) begin
            send(2'(i), 32'h10 + 32'(i));
            @(negedge clk);
            check("stream_in_ready", {63'd0, in_ready}, 64'd1);
            if (i > 0) check("stream_out_data", {32'd0, out_data[i-1]}, 64'h10 + 64'(i - 1));
            step();
        end
        in_valid = 1'b0;
        @(negedge clk);
        check("stream_last_data", {32'd0, out_data[3]}, 64'h13);
        check("stream_last_valid", {60'd0, out_valid}, 64'h8);
        step();
        @(negedge clk);
        check("stream_drained", {60'd0, out_valid}, 64'h0);

        // Blocked output 1
        out_ready = 4'b1101;
        send(2'd1, 32'h55);
        step();
        send(2'd1, 32'h66);
        @(negedge clk);
        check("blk_in_ready", {63'd0, in_ready}, 64'd0);
        check("blk_hold", {32'd0, out_data[1]}, 64'h55);
        step();
        @(negedge clk);
        check("blk_hold2", {32'd0, out_data[1]}, 64'h55);
        out_ready[1] = 1'b1;
        #1;
        check("unblk_in_ready", {63'd0, in_ready}, 64'd1);
        step();
        in_valid  = 1'b0;
        out_ready = 4'b0000;
        @(negedge clk);
        check("unblk_data", {32'd0, out_data[1]}, 64'h66);
        check("unblk_valid", {60'd0, out_valid}, 64'h2);

        // Isolation: output 1 stays full while output 3 loads
        step();
        send(2'd3, 32'h77);
        @(negedge clk);
        check("iso_in_ready", {63'd0, in_ready}, 64'd1);
        step();
        in_valid = 1'b0;
        @(negedge clk);
        check("iso_data3", {32'd0, out_data[3]}, 64'h77);
        check("iso_data1", {32'd0, out_data[1]}, 64'h66);
        check("iso_valid", {60'd0, out_valid}, 64'hA);

        // Fill remaining slots, then reset mid-cycle
        step();
        send(2'd0, 32'h88);
        step();
        send(2'd2, 32'h99);
        step();
        in_valid = 1'b0;
        @(negedge clk);
        check("full_valid", {60'd0, out_valid}, 64'hF);
        step();
        #2;
        chk_en = 1'b0;
        rst_n  = 1'b0;
        #1;
        check("async_rst_valid", {60'd0, out_valid}, 64'h0);
        check("async_rst_ready", {63'd0, in_ready}, 64'd0);
        step();
        rst_n  = 1'b1;
        chk_en = 1'b1;

`ifdef DEMUX4_COUNT_EN
        // 17 drains on output 0 wrap a 4-bit counter to 1
        out_ready = 4'b0001;
        for (int i = 0; i < 17; i++) begin
            send(2'd0, 32'h100 + 32'(i));
            step();
        end
        in_valid = 1'b0;
        step();
        @(negedge clk);
        check("cnt0_wrap", {60'd0, out_count[0]}, 64'd1);
        check("cnt1", {60'd0, out_count[1]}, 64'd0);
        check("cnt2", {60'd0, out_count[2]}, 64'd0);
        check("cnt3", {60'd0, out_count[3]}, 64'd0);
`endif

        step();
        chk_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
